// File: rtl/acc_control_unit.sv
// Sequencer for the SHA-256 accelerator: snoops a start command, fetches the
// message block, steps MS/CM through init and hash, then writes status and h0..h7.
//
// state          | meaning
// IDLE           | waiting for start bit written to HCB base
// READ_MESSAGE   | requesting the 512-bit block at HCB + msg offset
// WRITE_BUSY_BIT | writing busy=1 to ACB status word
// INIT           | one-cycle ms_init/cm_init pulse
// HASH           | ms_enable/cm_enable high for HASH_CYCLE_COUNT cycles
// WRITE_H        | writing hash word h_idx to ACB + h0 offset + 4*h_idx
// WRITE_DONE_BIT | writing done=1, busy=0 to ACB status word
module acc_control_unit #(
   parameter int MEM_LISTEN_ADDR_SIZE    = 16,
   parameter int MEM_LISTEN_DATA_SIZE    = 32,
   parameter int MEM_ACC_READ_ADDR_SIZE  = 16,
   parameter int MEM_ACC_READ_DATA_SIZE  = 512,
   parameter int MEM_ACC_WRITE_ADDR_SIZE = 16,
   parameter int MEM_ACC_WRITE_DATA_SIZE = 32,
   parameter logic [15:0] HCB_START_ADDR = 16'h1000,
   parameter logic [15:0] HCB_MSG_OFFSET = 16'h0008,
   parameter logic [15:0] ACB_START_ADDR = 16'h5000,
   parameter logic [15:0] ACB_H0_OFFSET  = 16'h0008,
   parameter int HASH_RESULT_LENGTH      = 256,
   parameter int HASH_CYCLE_COUNT        = 65
) (
   input  logic                               clk,
   input  logic                               rst_n,
   input  logic                               mem_listen_en,
   input  logic [MEM_LISTEN_ADDR_SIZE-1:0]    mem_listen_addr,
   input  logic [MEM_LISTEN_DATA_SIZE-1:0]    mem_listen_data,
   output logic                               mem_acc_read_en,
   output logic [MEM_ACC_READ_ADDR_SIZE-1:0]  mem_acc_read_addr,
   input  logic [MEM_ACC_READ_DATA_SIZE-1:0]  mem_acc_read_data,
   input  logic                               mem_acc_read_data_valid,
   output logic                               mem_acc_write_en,
   output logic [MEM_ACC_WRITE_ADDR_SIZE-1:0] mem_acc_write_addr,
   output logic [MEM_ACC_WRITE_DATA_SIZE-1:0] mem_acc_write_data,
   input  logic                               mem_acc_write_done,
   output logic [MEM_ACC_READ_DATA_SIZE-1:0]  ms_msg,
   output logic                               ms_init,
   output logic                               ms_enable,
   output logic                               cm_init,
   output logic                               cm_enable,
   input  logic [HASH_RESULT_LENGTH-1:0]      cm_out
);

   localparam int CNT_W = $clog2(HASH_CYCLE_COUNT + 1);
   localparam int WD_W  = MEM_ACC_WRITE_DATA_SIZE;

   typedef enum logic [2:0] {
      IDLE,
      READ_MESSAGE,
      WRITE_BUSY_BIT,
      INIT,
      HASH,
      WRITE_H,
      WRITE_DONE_BIT
   } state_t;

   state_t                            state_q, state_d;
   logic [2:0]                        h_idx_q, h_idx_d;
   logic [CNT_W-1:0]                  cnt_q, cnt_d;
   logic [MEM_ACC_READ_DATA_SIZE-1:0] msg_q, msg_d;
   logic [WD_W-1:0]                   wdata_q, wdata_d;
   logic                              start_cmd;
   logic                              unused_listen_bits;

   assign unused_listen_bits = ^mem_listen_data[MEM_LISTEN_DATA_SIZE-1:1];

   assign start_cmd = mem_listen_en && (mem_listen_addr == HCB_START_ADDR[MEM_LISTEN_ADDR_SIZE-1:0])
                      && mem_listen_data[0];

   // Hash word i is the i-th 32-bit slice counted from the MSB of cm_out.
   function automatic logic [WD_W-1:0] hash_word(input logic [HASH_RESULT_LENGTH-1:0] h,
                                                 input logic [2:0] i);
      logic [7:0] sh;
      sh = {3'd7 - i, 5'd0};
      return WD_W'(h >> sh);
   endfunction

   always_comb begin
      state_d = state_q;
      h_idx_d = h_idx_q;
      cnt_d   = cnt_q;
      msg_d   = msg_q;
      wdata_d = wdata_q;
      case (state_q)
         IDLE: begin
            if (start_cmd) state_d = READ_MESSAGE;
         end
         READ_MESSAGE: begin
            if (mem_acc_read_data_valid) begin
               msg_d   = mem_acc_read_data;
               wdata_d = WD_W'(1);
               state_d = WRITE_BUSY_BIT;
            end
         end
         WRITE_BUSY_BIT: begin
            if (mem_acc_write_done) begin
               wdata_d = '0;
               state_d = INIT;
            end
         end
         INIT: begin
            cnt_d   = '0;
            state_d = HASH;
         end
         HASH: begin
            if (cnt_q == CNT_W'(HASH_CYCLE_COUNT - 1)) begin
               h_idx_d = 3'd0;
               wdata_d = hash_word(cm_out, 3'd0);
               state_d = WRITE_H;
            end else begin
               cnt_d = cnt_q + 1'b1;
            end
         end
         WRITE_H: begin
            if (mem_acc_write_done) begin
               if (h_idx_q == 3'd7) begin
                  wdata_d = WD_W'(2);
                  state_d = WRITE_DONE_BIT;
               end else begin
                  h_idx_d = h_idx_q + 3'd1;
                  wdata_d = hash_word(cm_out, h_idx_q + 3'd1);
               end
            end
         end
         WRITE_DONE_BIT: begin
            if (mem_acc_write_done) begin
               wdata_d = '0;
               state_d = IDLE;
            end
         end
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state_q <= IDLE;
         h_idx_q <= '0;
         cnt_q   <= '0;
         msg_q   <= '0;
         wdata_q <= '0;
      end else begin
         state_q <= state_d;
         h_idx_q <= h_idx_d;
         cnt_q   <= cnt_d;
         msg_q   <= msg_d;
         wdata_q <= wdata_d;
      end
   end

   // Everything below is decoded from registered state only.
   always_comb begin
      mem_acc_read_en    = 1'b0;
      mem_acc_read_addr  = '0;
      mem_acc_write_en   = 1'b0;
      mem_acc_write_addr = '0;
      ms_init            = 1'b0;
      cm_init            = 1'b0;
      ms_enable          = 1'b0;
      cm_enable          = 1'b0;
      case (state_q)
         READ_MESSAGE: begin
            mem_acc_read_en   = 1'b1;
            mem_acc_read_addr = MEM_ACC_READ_ADDR_SIZE'(HCB_START_ADDR + HCB_MSG_OFFSET);
         end
         WRITE_BUSY_BIT, WRITE_DONE_BIT: begin
            mem_acc_write_en   = 1'b1;
            mem_acc_write_addr = MEM_ACC_WRITE_ADDR_SIZE'(ACB_START_ADDR);
         end
         INIT: begin
            ms_init = 1'b1;
            cm_init = 1'b1;
         end
         HASH: begin
            ms_enable = 1'b1;
            cm_enable = 1'b1;
         end
         WRITE_H: begin
            mem_acc_write_en   = 1'b1;
            mem_acc_write_addr = MEM_ACC_WRITE_ADDR_SIZE'(ACB_START_ADDR + ACB_H0_OFFSET
                                 + {11'd0, h_idx_q, 2'b00});
         end
         default: ;
      endcase
   end

   assign mem_acc_write_data = wdata_q;
   assign ms_msg             = msg_q;

endmodule

// File: tb/tb_acc_control_unit.sv
// Directed bench for acc_control_unit: reset, ignored snoops, two full
// transactions with delayed handshakes, and a reset during hashing.
module tb_acc_control_unit;

   logic         clk = 1'b0;
   logic         rst_n;
   logic         mem_listen_en;
   logic [15:0]  mem_listen_addr;
   logic [31:0]  mem_listen_data;
   logic         mem_acc_read_en;
   logic [15:0]  mem_acc_read_addr;
   logic [511:0] mem_acc_read_data;
   logic         mem_acc_read_data_valid;
   logic         mem_acc_write_en;
   logic [15:0]  mem_acc_write_addr;
   logic [31:0]  mem_acc_write_data;
   logic         mem_acc_write_done;
   logic [511:0] ms_msg;
   logic         ms_init, ms_enable, cm_init, cm_enable;
   logic [255:0] cm_out;

   int n_tests = 0;
   int n_fail  = 0;
   logic [31:0] exp_h [8];

   always #5 clk = ~clk;

   acc_control_unit dut (
      .clk                     (clk),
      .rst_n                   (rst_n),
      .mem_listen_en           (mem_listen_en),
      .mem_listen_addr         (mem_listen_addr),
      .mem_listen_data         (mem_listen_data),
      .mem_acc_read_en         (mem_acc_read_en),
      .mem_acc_read_addr       (mem_acc_read_addr),
      .mem_acc_read_data       (mem_acc_read_data),
      .mem_acc_read_data_valid (mem_acc_read_data_valid),
      .mem_acc_write_en        (mem_acc_write_en),
      .mem_acc_write_addr      (mem_acc_write_addr),
      .mem_acc_write_data      (mem_acc_write_data),
      .mem_acc_write_done      (mem_acc_write_done),
      .ms_msg                  (ms_msg),
      .ms_init                 (ms_init),
      .ms_enable               (ms_enable),
      .cm_init                 (cm_init),
      .cm_enable               (cm_enable),
      .cm_out                  (cm_out)
   );

   task automatic chk(input string tag, input logic [511:0] got, input logic [511:0] exp);
      n_tests++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h", tag, got, exp);
      end
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic chk_quiet(input string tag);
      chk({tag, "_ctl"}, {mem_acc_read_en, mem_acc_write_en, ms_init, cm_init, ms_enable, cm_enable}, '0);
      chk({tag, "_addr"}, {mem_acc_read_addr, mem_acc_write_addr}, '0);
   endtask

   task automatic start_cmd(input logic [15:0] a, input logic [31:0] d);
      mem_listen_en   = 1'b1;
      mem_listen_addr = a;
      mem_listen_data = d;
      step();
      mem_listen_en   = 1'b0;
      mem_listen_addr = '0;
      mem_listen_data = '0;
   endtask

   // Checks a held write request, waits `dly` cycles, then completes it.
   task automatic do_write(input string tag, input logic [15:0] a, input logic [31:0] d, input int dly);
      chk({tag, "_en"}, mem_acc_write_en, 1'b1);
      chk({tag, "_addr"}, mem_acc_write_addr, a);
      chk({tag, "_data"}, mem_acc_write_data, d);
      for (int k = 0; k < dly; k++) begin
         step();
         chk({tag, "_hold"}, {mem_acc_write_en, mem_acc_write_addr, mem_acc_write_data}, {1'b1, a, d});
      end
      mem_acc_write_done = 1'b1;
      step();
      mem_acc_write_done = 1'b0;
   endtask

   // Drives start through busy write and the init pulse; leaves the DUT in first HASH cycle.
   task automatic to_hash(input logic [511:0] msg);
      start_cmd(16'h1000, 32'h1);
      chk("rd_en", mem_acc_read_en, 1'b1);
      chk("rd_addr", mem_acc_read_addr, 16'h1008);
      mem_acc_write_done = 1'b1;
      step();
      mem_acc_write_done = 1'b0;
      for (int k = 0; k < 4; k++) step();
      chk("rd_wait", {mem_acc_read_en, mem_acc_write_en}, 2'b10);
      mem_acc_read_data       = msg;
      mem_acc_read_data_valid = 1'b1;
      step();
      mem_acc_read_data_valid = 1'b0;
      mem_acc_read_data       = '0;
      chk("ms_msg", ms_msg, msg);
      chk("rd_drop", mem_acc_read_en, 1'b0);
      do_write("busy", 16'h5000, 32'h1, 2);
      chk("init", {ms_init, cm_init, ms_enable, cm_enable, mem_acc_write_en}, 5'b11000);
      step();
   endtask

   task automatic full_txn(input logic [511:0] msg);
      int n;
      to_hash(msg);
      n = 0;
      while (ms_enable && cm_enable && n < 200) begin
         n++;
         step();
      end
      chk("hash_cycles", n, 65);
      chk("hash_off", {ms_init, cm_init, ms_enable, cm_enable}, 4'b0000);
      for (int i = 0; i < 8; i++)
         do_write($sformatf("h%0d", i), 16'h5008 + 16'(4 * i), exp_h[i], 3);
      do_write("done", 16'h5000, 32'h2, 1);
      chk_quiet("idle");
   endtask

   initial begin
      int wcount;
      rst_n                   = 1'b0;
      mem_listen_en           = 1'b0;
      mem_listen_addr         = '0;
      mem_listen_data         = '0;
      mem_acc_read_data       = '0;
      mem_acc_read_data_valid = 1'b0;
      mem_acc_write_done      = 1'b0;
      cm_out                  = '0;
      step();
      step();
      chk_quiet("rst");
      chk("rst_data", {mem_acc_write_data, ms_msg}, '0);
      rst_n = 1'b1;
      step();

      start_cmd(16'h1004, 32'h1);
      chk("ign_addr", mem_acc_read_en, 1'b0);
      start_cmd(16'h1000, 32'h0);
      chk("ign_data", mem_acc_read_en, 1'b0);

      cm_out = 256'h00000001_00000002_00000003_00000004_00000005_00000006_00000007_00000008;
      exp_h = '{32'h1, 32'h2, 32'h3, 32'h4, 32'h5, 32'h6, 32'h7, 32'h8};
      full_txn({64{8'hA5}});

      cm_out = 256'hDEADBEEF_CAFEF00D_01234567_89ABCDEF_FFFFFFFF_00000000_13579BDF_2468ACE0;
      exp_h = '{32'hDEADBEEF, 32'hCAFEF00D, 32'h01234567, 32'h89ABCDEF,
                32'hFFFFFFFF, 32'h00000000, 32'h13579BDF, 32'h2468ACE0};
      full_txn({16{32'h0F1E2D3C}});
      chk("msg_hold", ms_msg, {16{32'h0F1E2D3C}});

      to_hash({8{64'h5A5A_0000_FFFF_1234}});
      for (int k = 0; k < 30; k++) step();
      chk("mid_hash", {ms_enable, cm_enable}, 2'b11);
      rst_n = 1'b0;
      step();
      chk_quiet("mid_rst");
      chk("mid_rst_data", {mem_acc_write_data, ms_msg}, '0);
      rst_n = 1'b1;
      wcount = 0;
      for (int k = 0; k < 100; k++) begin
         step();
         if (mem_acc_write_en || ms_enable) wcount++;
      end
      chk("post_rst_quiet", wcount, 0);

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
